scff_chain_tester: RTL and testbench

Synthesizable scan-chain pulse-walk tester for the FPGA fabric's scan-flip-flop (scff) chains. It drives a single-cycle '1' into every chain head, then shifts zeros. It checks each chain tail for exact arrival of the pulse after CHAIN_LEN clocks and for a clean zero before and after it. Results are reported as error count, failing-chain mask and pass/done status. It sits between the SoC-side control logic and the fabric's sc_head/sc_tail pins, on the fabric operating clock, and supports multiple parallel chains.

---
 rtl/scff_tester_pkg.sv | 22 ++
 rtl/scff_chain_tester_if.sv | 35 +++
 rtl/scff_err_popcount.sv | 19 +
 rtl/scff_chain_tester.sv | 166 ++++++++++++++++
 tb/tb_scff_chain_tester.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scff_tester_pkg.sv
// Shared types and constants for the scan-chain pulse-walk tester.
//   state_t            - tester FSM state encoding
//   ERR_W_DEFAULT      - default width of the saturating error counter
//   meas_width()       - width of the cycle counter / measured-length field
package scff_tester_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INJECT = 3'd1,
        SHIFT  = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int ERR_W_DEFAULT = 16;

    // Wide enough to hold every cnt value a run can reach.
    function automatic int meas_width(input int chain_len, input int check_cycles);
        return $clog2(chain_len + check_cycles + 1);
    endfunction

endpackage

// File: rtl/scff_chain_tester_if.sv
// Control/observation bundle between the SoC-side controller, the scan-chain
// tester and the fabric scan pins.
//   start           controller -> tester, begins a test (sampled in IDLE)
//   sc_head         tester -> fabric, chain head drive
//   sc_tail         fabric -> tester, chain tail observation
//   test_en, busy   tester status, high while a test is running
//   done            one-cycle completion pulse
//   pass, err_cnt, err_chain_mask, meas_len   results, held until next start
// Modports: slave = tester side, master = controller/fabric side.
interface scff_chain_tester_if #(
    parameter int NUM_CHAINS = 1,
    parameter int ERR_W      = 16,
    parameter int MEAS_W     = 11
);
    logic                  start;
    logic [NUM_CHAINS-1:0] sc_head;
    logic [NUM_CHAINS-1:0] sc_tail;
    logic                  test_en;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [ERR_W-1:0]      err_cnt;
    logic [NUM_CHAINS-1:0] err_chain_mask;
    logic [MEAS_W-1:0]     meas_len;

    modport slave (
        input  start, sc_tail,
        output sc_head, test_en, busy, done, pass, err_cnt, err_chain_mask, meas_len
    );

    modport master (
        output start, sc_tail,
        input  sc_head, test_en, busy, done, pass, err_cnt, err_chain_mask, meas_len
    );
endinterface

// File: rtl/scff_err_popcount.sv
// Combinational population count of the per-chain mismatch vector.
//   vec  in   N-bit mismatch vector
//   cnt  out  number of set bits in vec
module scff_err_popcount #(
    parameter int N = 1,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + W'(vec[i]);
        end
    end

endmodule

// File: rtl/scff_chain_tester.sv
// Scan-chain pulse-walk tester. Injects a single '1' into every chain head,
// shifts zeros behind it and checks that each tail shows the pulse exactly
// CHAIN_LEN cycles later with clean zeros before and after.
//   op_clk   in   fabric operating clock, rising edge
//   greset   in   synchronous active-high reset
//   bus      slave modport of scff_chain_tester_if (start, sc_head, sc_tail,
//            test_en, busy, done, pass, err_cnt, err_chain_mask, meas_len)
// Optional feature: define SCFF_TESTER_LEN_MEASURE_EN to record the cnt value
// at which chain 0's tail first reads '1' (meas_len); otherwise meas_len is 0.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | heads low, waiting for start
// INJECT | cnt=0, drive '1' into every head, tails ignored
// SHIFT  | cnt 1..CHAIN_LEN-1, heads low, tails must read 0
// CHECK  | cnt CHAIN_LEN.., tail must be 1 at arrival, 0 afterwards
// DONE   | one-cycle done pulse, pass latched
module scff_chain_tester
    import scff_tester_pkg::*;
#(
    parameter int NUM_CHAINS   = 1,
    parameter int CHAIN_LEN    = 1024,
    parameter int CHECK_CYCLES = 3,
    parameter int ERR_W        = ERR_W_DEFAULT
) (
    input  logic                 op_clk,
    input  logic                 greset,
    scff_chain_tester_if.slave   bus
);

    localparam int CNT_W = meas_width(CHAIN_LEN, CHECK_CYCLES);
    localparam int PC_W  = $clog2(NUM_CHAINS + 1);
    localparam int SUM_W = ((ERR_W > PC_W) ? ERR_W : PC_W) + 1;

    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] ARRIVE     = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_CHECK = CNT_W'(CHAIN_LEN + CHECK_CYCLES - 1);
    localparam logic [SUM_W-1:0] ERR_MAX    = (SUM_W'(1) << ERR_W) - SUM_W'(1);

    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;

    logic head_d, busy_d, done_d;
    logic [NUM_CHAINS-1:0] sc_head_q;
    logic test_en_q, busy_q, done_q;

    logic                  pass_q;
    logic [ERR_W-1:0]      err_cnt_q;
    logic [ERR_W-1:0]      err_nxt;
    logic [NUM_CHAINS-1:0] mask_q;
    logic [NUM_CHAINS-1:0] expected;
    logic [NUM_CHAINS-1:0] mismatch;
    logic [PC_W-1:0]       mism_cnt;
    logic [SUM_W-1:0]      err_sum;
    logic                  checking;
    logic                  start_run;

    assign start_run = (state == IDLE) && bus.start;
    assign checking  = (state == SHIFT) || (state == CHECK);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge op_clk) begin
        if (greset) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = INJECT;
            INJECT:  state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST_SHIFT) state_nxt = CHECK;
            CHECK:   if (cnt == LAST_CHECK) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: output decode ----------------
    // Decoded from the next state and registered, so the pins change on the
    // same edge as the state they belong to.
    always_comb begin
        head_d = (state_nxt == INJECT);
        busy_d = (state_nxt == INJECT) || (state_nxt == SHIFT) || (state_nxt == CHECK);
        done_d = (state_nxt == DONE);
    end

    always_ff @(posedge op_clk) begin
        if (greset) begin
            sc_head_q <= '0;
            test_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sc_head_q <= {NUM_CHAINS{head_d}};
            test_en_q <= busy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // cnt tracks position of the pulse: 0 in INJECT, CHAIN_LEN at expected arrival.
    always_ff @(posedge op_clk) begin
        if (greset || state == IDLE || state == DONE) cnt <= '0;
        else                                          cnt <= cnt + CNT_W'(1);
    end

    // ---------------- error accumulation ----------------
    always_comb begin
        expected = '0;
        if (state == CHECK && cnt == ARRIVE) expected = '1;
        mismatch = checking ? (bus.sc_tail ^ expected) : '0;
    end

    scff_err_popcount #(
        .N (NUM_CHAINS),
        .W (PC_W)
    ) u_popcount (
        .vec (mismatch),
        .cnt (mism_cnt)
    );

    always_comb begin
        err_sum = SUM_W'(err_cnt_q) + SUM_W'(mism_cnt);
        err_nxt = (err_sum > ERR_MAX) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge op_clk) begin
        if (greset || start_run) begin
            err_cnt_q <= '0;
            mask_q    <= '0;
            pass_q    <= 1'b0;
        end else begin
            err_cnt_q <= err_nxt;
            mask_q    <= mask_q | mismatch;
            // err_nxt already includes the final CHECK sample, so pass is
            // valid in the same cycle as done.
            if (state == CHECK && cnt == LAST_CHECK) pass_q <= (err_nxt == '0);
        end
    end

    // ---------------- optional length measurement ----------------
`ifdef SCFF_TESTER_LEN_MEASURE_EN
    logic [CNT_W-1:0] meas_q;

    // cnt is never 0 while checking, so meas_q==0 doubles as "not yet seen".
    always_ff @(posedge op_clk) begin
        if (greset || start_run)                           meas_q <= '0;
        else if (checking && bus.sc_tail[0] && meas_q == '0) meas_q <= cnt;
    end

    assign bus.meas_len = meas_q;
`else
    assign bus.meas_len = '0;
`endif

    assign bus.sc_head        = sc_head_q;
    assign bus.test_en        = test_en_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_cnt        = err_cnt_q;
    assign bus.err_chain_mask = mask_q;

endmodule

// File: tb/tb_scff_chain_tester.sv
module tb_scff_chain_tester;

`ifdef SCFF_TESTER_LEN_MEASURE_EN
    localparam bit MEAS_ON = 1'b1;
`else
    localparam bit MEAS_ON = 1'b0;
`endif

    logic op_clk;
    logic greset;
    logic start_drv;
    logic [1:0] tail;

    int n_vec = 0;
    int n_err = 0;

    scff_chain_tester_if #(.NUM_CHAINS(2), .ERR_W(16), .MEAS_W(4)) ifa ();
    scff_chain_tester_if #(.NUM_CHAINS(2), .ERR_W(3),  .MEAS_W(4)) ifb ();

    assign ifa.start   = start_drv;
    assign ifb.start   = start_drv;
    assign ifa.sc_tail = tail;
    assign ifb.sc_tail = tail;

    scff_chain_tester #(.NUM_CHAINS(2), .CHAIN_LEN(8), .CHECK_CYCLES(3), .ERR_W(16)) dut_a (
        .op_clk (op_clk),
        .greset (greset),
        .bus    (ifa.slave)
    );

    scff_chain_tester #(.NUM_CHAINS(2), .CHAIN_LEN(8), .CHECK_CYCLES(3), .ERR_W(3)) dut_b (
        .op_clk (op_clk),
        .greset (greset),
        .bus    (ifb.slave)
    );

    initial begin
        op_clk = 1'b0;
        forever #5 op_clk = ~op_clk;
    end

    // Fabric model: two shift-register chains driven by dut_a's heads.
    logic [7:0] sr0 = '0;
    logic [7:0] sr1 = '0;
    int  len1   = 8;
    bit  stuck0 = 1'b0;

    always @(posedge op_clk) begin
        sr0 <= {sr0[6:0], ifa.sc_head[0]};
        sr1 <= {sr1[6:0], ifa.sc_head[1]};
    end

    always_comb begin
        tail[0] = stuck0 ? 1'b1 : sr0[7];
        tail[1] = sr1[len1-1];
    end

    localparam logic [3:0] MEAS_GOOD  = MEAS_ON ? 4'd8 : 4'd0;
    localparam logic [3:0] MEAS_STUCK = MEAS_ON ? 4'd1 : 4'd0;

    task automatic idle(input int n);
        repeat (n) @(negedge op_clk);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the INJECT cycle (cycle 1).
    task automatic kick();
        start_drv = 1'b1;
        @(negedge op_clk);
        start_drv = 1'b0;
    endtask

    // Advance negedge by negedge until done, bounded; cyc is the cycle index after the start edge.
    task automatic wait_done(input int from, output int cyc);
        cyc = from;
        while (ifa.done !== 1'b1 && cyc < 64) begin
            @(negedge op_clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        greset = 1'b1;
        start_drv = 1'b0;
        idle(3);
        n_vec++;
        if ({ifa.sc_head, ifa.test_en, ifa.busy, ifa.done, ifa.pass, ifa.err_cnt,
             ifa.err_chain_mask, ifa.meas_len} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got sc_head=%b test_en=%b busy=%b done=%b pass=%b err=%0d mask=%b meas=%0d, need all 0",
                     ifa.sc_head, ifa.test_en, ifa.busy, ifa.done, ifa.pass, ifa.err_cnt, ifa.err_chain_mask, ifa.meas_len);
        end
        greset = 1'b0;
        idle(10);
    endtask

    task automatic test_good_chains();
        int cyc;
        idle(16);
        kick();
        n_vec++;
        if ({ifa.sc_head, ifa.test_en, ifa.busy} !== 4'b1111) begin
            n_err++;
            $display("FAIL inject_outputs: got head/ten/busy=%b need 1111", {ifa.sc_head, ifa.test_en, ifa.busy});
        end
        @(negedge op_clk);
        n_vec++;
        if ({ifa.sc_head, ifa.test_en, ifa.busy} !== 4'b0011) begin
            n_err++;
            $display("FAIL shift_outputs: got head/ten/busy=%b need 0011", {ifa.sc_head, ifa.test_en, ifa.busy});
        end
        wait_done(2, cyc);
        n_vec++;
        if (cyc !== 12) begin n_err++; $display("FAIL good_latency: got %0d need 12", cyc); end
        n_vec++;
        if ({ifa.pass, ifa.err_cnt, ifa.err_chain_mask} !== {1'b1, 16'd0, 2'b00}) begin
            n_err++;
            $display("FAIL good_result: got pass=%b err=%0d mask=%b need 1 0 00", ifa.pass, ifa.err_cnt, ifa.err_chain_mask);
        end
        n_vec++;
        if (ifa.meas_len !== MEAS_GOOD) begin n_err++; $display("FAIL good_meas: got %0d need %0d", ifa.meas_len, MEAS_GOOD); end
        @(negedge op_clk);
        n_vec++;
        if ({ifa.done, ifa.busy, ifa.test_en, ifa.pass} !== 4'b0001) begin
            n_err++;
            $display("FAIL good_after: got done/busy/ten/pass=%b need 0001", {ifa.done, ifa.busy, ifa.test_en, ifa.pass});
        end
    endtask

    task automatic test_short_chain();
        int cyc;
        len1 = 7;
        idle(16);
        kick();
        wait_done(1, cyc);
        n_vec++;
        if (cyc !== 12) begin n_err++; $display("FAIL short_latency: got %0d need 12", cyc); end
        n_vec++;
        if ({ifa.pass, ifa.err_cnt, ifa.err_chain_mask} !== {1'b0, 16'd2, 2'b10}) begin
            n_err++;
            $display("FAIL short_result: got pass=%b err=%0d mask=%b need 0 2 10", ifa.pass, ifa.err_cnt, ifa.err_chain_mask);
        end
        n_vec++;
        if (ifa.meas_len !== MEAS_GOOD) begin n_err++; $display("FAIL short_meas: got %0d need %0d", ifa.meas_len, MEAS_GOOD); end
        n_vec++;
        if (ifb.err_cnt !== 3'd2) begin n_err++; $display("FAIL short_err_w3: got %0d need 2", ifb.err_cnt); end
        len1 = 8;
    endtask

    task automatic test_stuck_tail();
        int cyc;
        stuck0 = 1'b1;
        idle(16);
        kick();
        wait_done(1, cyc);
        n_vec++;
        if ({ifa.pass, ifa.err_cnt, ifa.err_chain_mask} !== {1'b0, 16'd9, 2'b01}) begin
            n_err++;
            $display("FAIL stuck_result: got pass=%b err=%0d mask=%b need 0 9 01", ifa.pass, ifa.err_cnt, ifa.err_chain_mask);
        end
        n_vec++;
        if (ifa.meas_len !== MEAS_STUCK) begin n_err++; $display("FAIL stuck_meas: got %0d need %0d", ifa.meas_len, MEAS_STUCK); end
        n_vec++;
        if (ifb.err_cnt !== 3'd7) begin n_err++; $display("FAIL stuck_saturate: got %0d need 7", ifb.err_cnt); end
        n_vec++;
        if (ifb.pass !== 1'b0) begin n_err++; $display("FAIL stuck_pass_w3: got %b need 0", ifb.pass); end
        stuck0 = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        stuck0 = 1'b1;
        idle(16);
        kick();
        repeat (4) @(negedge op_clk);
        n_vec++;
        if (ifa.err_cnt !== 16'd3) begin n_err++; $display("FAIL midrun_err: got %0d need 3", ifa.err_cnt); end
        greset = 1'b1;
        @(negedge op_clk);
        greset = 1'b0;
        n_vec++;
        if ({ifa.sc_head, ifa.test_en, ifa.busy, ifa.done, ifa.pass, ifa.err_cnt,
             ifa.err_chain_mask, ifa.meas_len} !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: got sc_head=%b test_en=%b busy=%b done=%b pass=%b err=%0d mask=%b meas=%0d, need all 0",
                     ifa.sc_head, ifa.test_en, ifa.busy, ifa.done, ifa.pass, ifa.err_cnt, ifa.err_chain_mask, ifa.meas_len);
        end
        stuck0 = 1'b0;
        idle(12);
        kick();
        wait_done(1, cyc);
        n_vec++;
        if (cyc !== 12) begin n_err++; $display("FAIL post_reset_latency: got %0d need 12", cyc); end
        n_vec++;
        if ({ifa.pass, ifa.err_cnt, ifa.err_chain_mask} !== {1'b1, 16'd0, 2'b00}) begin
            n_err++;
            $display("FAIL post_reset_result: got pass=%b err=%0d mask=%b need 1 0 00", ifa.pass, ifa.err_cnt, ifa.err_chain_mask);
        end
    endtask

    task automatic test_back_to_back();
        int nd;
        int dc[4];
        nd = 0;
        dc = '{default: 0};
        idle(16);
        start_drv = 1'b1;
        @(negedge op_clk);
        for (int c = 1; c <= 45; c++) begin
            if (ifa.done === 1'b1) begin
                if (nd < 4) dc[nd] = c;
                nd++;
                n_vec++;
                if (ifa.pass !== 1'b1 || ifa.err_cnt !== 16'd0) begin
                    n_err++;
                    $display("FAIL b2b_pass: run %0d got pass=%b err=%0d need 1 0", nd, ifa.pass, ifa.err_cnt);
                end
            end
            @(negedge op_clk);
        end
        start_drv = 1'b0;
        n_vec++;
        if (nd !== 3) begin n_err++; $display("FAIL b2b_count: got %0d done pulses need 3", nd); end
        n_vec++;
        if (dc[0] !== 12 || dc[1] !== 25 || dc[2] !== 38) begin
            n_err++;
            $display("FAIL b2b_timing: got %0d %0d %0d need 12 25 38", dc[0], dc[1], dc[2]);
        end
    endtask

    task automatic test_start_during_busy();
        int cyc;
        int extra;
        idle(24);
        kick();
        repeat (3) @(negedge op_clk);
        start_drv = 1'b1;
        @(negedge op_clk);
        start_drv = 1'b0;
        wait_done(5, cyc);
        n_vec++;
        if (cyc !== 12) begin n_err++; $display("FAIL busy_start_latency: got %0d need 12", cyc); end
        n_vec++;
        if (ifa.pass !== 1'b1) begin n_err++; $display("FAIL busy_start_pass: got %b need 1", ifa.pass); end
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge op_clk);
            if (ifa.done === 1'b1) extra++;
        end
        n_vec++;
        if (extra !== 0) begin n_err++; $display("FAIL busy_start_rerun: got %0d extra done pulses need 0", extra); end
    endtask

    initial begin
        greset    = 1'b1;
        start_drv = 1'b0;
        test_reset();
        test_good_chains();
        test_short_chain();
        test_stuck_tail();
        test_reset_mid_run();
        test_back_to_back();
        test_start_during_busy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
